// File: rtl/bf_tape_if.sv
// bf_tape_if: command/response bus between the bf-machine sequencer and the
// data-tape unit.
//   cmd_valid/cmd_op/cmd_data : command from sequencer (held until accepted)
//   cmd_ready                 : tape accepts a command this cycle
//   rsp_valid/rsp_data        : one-cycle CELL_RD result pulse; data holds after
// master = sequencer side, slave = tape side.
interface bf_tape_if #(
  parameter int DW = 8
);
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bf_tape.sv
// bf_tape: data tape of the bf-machine. Holds the cell RAM, the data pointer
// and a register (cur) mirroring mem[ptr], so cell ops need no RAM read.
// After reset or a CLEAR command the RAM is zeroed by a DEPTH-cycle sweep.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : command/response handshake, see bf_tape_if
//   cell_zero    : cur == 0, for '[' / ']' decisions (valid while cmd_ready)
//   ptr          : current data pointer
//   busy         : clear sweep in progress
//   ptr_err      : only with TAPE_BOUNDS_EN; sticky out-of-range pointer move
// Optional feature macro: TAPE_BOUNDS_EN (pointer moves past either end are
// refused instead of wrapping).
module bf_tape #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clock,
  input  logic          reset,
  bf_tape_if.slave      bus,
  output logic          cell_zero,
  output logic [AW-1:0] ptr,
`ifdef TAPE_BOUNDS_EN
  output logic          ptr_err,
`endif
  output logic          busy
);

  localparam logic [2:0] OP_NOP = 3'd0, OP_PINC = 3'd1, OP_PDEC = 3'd2,
                         OP_CINC = 3'd3, OP_CDEC = 3'd4, OP_WR = 3'd5,
                         OP_RD = 3'd6, OP_CLR = 3'd7;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_FETCH} state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [AW-1:0] ptr_q, ptr_n;
  logic [DW-1:0] cur, cur_n;
  logic          rv_q, rv_n;
  logic [DW-1:0] rd_q, rd_n;
  logic [DW-1:0] ram_q;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
`ifdef TAPE_BOUNDS_EN
  logic          err_q, err_n;
`endif

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_CLEAR;
      cnt   <= '0;
      ptr_q <= '0;
      cur   <= '0;
      rv_q  <= 1'b0;
      rd_q  <= '0;
`ifdef TAPE_BOUNDS_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr_q <= ptr_n;
      cur   <= cur_n;
      rv_q  <= rv_n;
      rd_q  <= rd_n;
`ifdef TAPE_BOUNDS_EN
      err_q <= err_n;
`endif
    end
  end

  // RAM: the read always targets the next pointer, so after a move the FETCH
  // cycle sees mem[new ptr]. A write in the same cycle as a move is to the old
  // address, which always differs from the new one (DEPTH >= 2).
  always_ff @(posedge clock) begin
    if (we && !reset) mem[waddr] <= wdata;
    ram_q <= mem[ptr_n];
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr_q;
    cur_n   = cur;
    rv_n    = 1'b0;
    rd_n    = rd_q;
    we      = 1'b0;
    waddr   = ptr_q;
    wdata   = cur;
`ifdef TAPE_BOUNDS_EN
    err_n   = err_q;
`endif
    case (state)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        wdata = '0;
        if (cnt == LAST) begin
          state_n = S_IDLE;
          ptr_n   = '0;
          cur_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_CINC: begin
              cur_n = cur + DW'(1);
              we    = 1'b1;
              wdata = cur_n;
            end
            OP_CDEC: begin
              cur_n = cur - DW'(1);
              we    = 1'b1;
              wdata = cur_n;
            end
            OP_WR: begin
              cur_n = bus.cmd_data;
              we    = 1'b1;
              wdata = bus.cmd_data;
            end
            OP_RD: begin
              rv_n = 1'b1;
              rd_n = cur;
            end
            OP_PINC: begin
`ifdef TAPE_BOUNDS_EN
              if (ptr_q == LAST) begin
                err_n = 1'b1;
              end else begin
                ptr_n   = ptr_q + AW'(1);
                state_n = S_FETCH;
              end
`else
              ptr_n   = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
              state_n = S_FETCH;
`endif
            end
            OP_PDEC: begin
`ifdef TAPE_BOUNDS_EN
              if (ptr_q == '0) begin
                err_n = 1'b1;
              end else begin
                ptr_n   = ptr_q - AW'(1);
                state_n = S_FETCH;
              end
`else
              ptr_n   = (ptr_q == '0) ? LAST : ptr_q - AW'(1);
              state_n = S_FETCH;
`endif
            end
            OP_CLR: begin
              // Same as reset entry, but the last CELL_RD result is kept.
              state_n = S_CLEAR;
              cnt_n   = '0;
              ptr_n   = '0;
              cur_n   = '0;
`ifdef TAPE_BOUNDS_EN
              err_n   = 1'b0;
`endif
            end
            default: ;  // OP_NOP
          endcase
        end
      end
      S_FETCH: begin
        cur_n   = ram_q;
        state_n = S_IDLE;
      end
      default: state_n = S_CLEAR;
    endcase
    // Keep the RAM read address consistent with what reset loads into ptr.
    if (reset) ptr_n = '0;
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = rd_q;
  assign cell_zero     = (cur == '0);
  assign ptr           = ptr_q;
  assign busy          = (state == S_CLEAR);
`ifdef TAPE_BOUNDS_EN
  assign ptr_err       = err_q;
`endif

endmodule

// File: doc/bf_tape.md
Name: bf_tape

Overview:
- Parametrised data-tape unit for the bf-machine: cell RAM, data pointer and current-cell cache in one block.
- Executes tape commands from the instruction sequencer ('>', '<', '+', '-', ',', '.', plus a clear command).
- Exposes a zero flag that drives '[' and ']' branch decisions.
- Replaces the bare data RAM. Clears by walking every address after reset instead of a one-shot clear.

Parameters:
DW, 8, cell data width in bits.
AW, 8, pointer/address width in bits.
DEPTH, 256, number of cells; must satisfy 2 <= DEPTH <= 2**AW.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_op  in  3  0 NOP, 1 PTR_INC, 2 PTR_DEC, 3 CELL_INC, 4 CELL_DEC, 5 CELL_WR, 6 CELL_RD, 7 CLEAR.
cmd_data  in  DW  value for CELL_WR (the ',' input byte).
cmd_ready  out  1  command accepted in any cycle with cmd_valid && cmd_ready.
rsp_valid  out  1  one-cycle pulse carrying the CELL_RD result.
rsp_data  out  DW  cell value; valid when rsp_valid is high.
cell_zero  out  1  current cell == 0; meaningful only while cmd_ready is high.
ptr  out  AW  current data pointer.
busy  out  1  high while a clear sweep is in progress.

Behaviour:
- Clock port is clock; reset is synchronous and active-high, named reset.
- Storage: DEPTH x DW RAM, one synchronous write port and one synchronous read port, 1-cycle read latency. cur register mirrors mem[ptr].
- FSM states: CLEAR, IDLE, FETCH.
- Reset, from any state and in any cycle, including mid-sweep or mid-FETCH:
  - state = CLEAR; clear counter = 0; ptr = 0; cur = 0.
  - Outputs: cmd_ready = 0, rsp_valid = 0, rsp_data = 0, busy = 1, cell_zero = 1.
- CLEAR:
  - Each cycle writes 0 to mem[counter], then counter++.
  - After writing DEPTH-1: state goes to IDLE; ptr = 0, cur = 0, busy = 0.
  - The sweep takes exactly DEPTH cycles after reset deasserts. cmd_ready = 0 throughout.
- IDLE: cmd_ready = 1. On an accepted command:
  - NOP: no effect.
  - CELL_INC / CELL_DEC: cur ±1 modulo 2**DW, and the new value is written to mem[ptr] in the same cycle. 255+1 = 0 and 0-1 = 255 for DW = 8. Stays in IDLE, so back-to-back cell ops run at 1 per cycle.
  - CELL_WR: cur = cmd_data; mem[ptr] = cmd_data; stays in IDLE.
  - CELL_RD: next cycle rsp_valid = 1 and rsp_data = cur at acceptance. There is no backpressure. rsp_data holds its value until the next CELL_RD.
  - PTR_INC / PTR_DEC: new ptr = ptr ± 1, wrapping at DEPTH: DEPTH-1 goes to 0, and 0 goes to DEPTH-1. The RAM read is issued at the new address; state goes to FETCH.
  - CLEAR: same entry as reset, except rsp_data is retained.
- FETCH:
  - cmd_ready = 0; cur is loaded from RAM output; state returns to IDLE.
  - A pointer move therefore costs 2 cycles; the next command is accepted 2 cycles after the move.
- Hazards:
  - A cell write followed immediately by a pointer move never reads the address just written (the addresses differ).
  - Returning to that cell later reads the updated value. No bypass is required.
  - If DEPTH = 1, wrap is a self-move, which is disallowed by the DEPTH parameter range.
- cell_zero = (cur == 0), driven directly from the register with no added latency.
- Commands presented while cmd_ready = 0 are ignored, not queued. The sequencer must hold cmd_valid.

Optional Feature:
TAPE_BOUNDS_EN
- Defined:
  - Adds output port ptr_err (1 bit), reset to 0.
  - PTR_INC at DEPTH-1 or PTR_DEC at 0 does not move the pointer and does not enter FETCH; the command completes in 1 cycle.
  - The command sets ptr_err, which is sticky until reset or CLEAR.
- Undefined: pointer wraps as described above; no ptr_err port exists.

Test Plan:
- Reset held 3 cycles, then released (DEPTH = 256) -> busy = 1 and cmd_ready = 0 for exactly 256 cycles. Then ptr = 0, cell_zero = 1, and a CELL_RD returns 0 at every address visited.
- CELL_WR 0x41, CELL_INC x2, CELL_RD -> rsp_valid pulses one cycle later with rsp_data = 0x43; cell_zero = 0.
- CELL_DEC at 0x00 -> 0xFF; then CELL_INC -> 0x00 and cell_zero = 1.
- Sequence:
  - CELL_WR 7 at ptr 0, then PTR_INC and CELL_WR 9.
  - Then PTR_DEC, then CELL_RD.
  - Expected: rsp_data = 7 and ptr = 0. Each pointer move holds cmd_ready low for exactly 1 cycle.
- PTR_DEC at ptr 0:
  - Macro undefined: ptr = 255 and cur = mem[255] = 0.
  - TAPE_BOUNDS_EN defined: ptr stays 0, ptr_err = 1, no FETCH cycle.
- Reset asserted in the FETCH cycle, and again mid-sweep at counter 100 -> sweep restarts from 0; busy stays high for a full 256 cycles after the final release; cells written earlier read 0.
